// File: rtl/audio_serdes.sv
// audio_serdes: WM8731 serial port with MCLK/BCLK/LRCLK generation, TX/RX frame FIFOs and sticky error flags
module audio_serdes #(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int MCLK_DIV   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fmt,
  input  logic                  mute,
  output logic                  m_clk,
  output logic                  b_clk,
  output logic                  lr_clk,
  output logic                  dacdat,
  input  logic                  adcdat,
  input  logic [2*SAMPLE_W-1:0] tx_data,
  input  logic                  tx_wr,
  output logic                  tx_full,
  output logic [2*SAMPLE_W-1:0] rx_data,
  input  logic                  rx_rd,
  output logic                  rx_empty,
  output logic                  tx_underrun,
  output logic                  rx_overrun,
  input  logic                  clr_err,
  output logic                  frame_tick
);
  localparam int FW = 2*SAMPLE_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(2*SLOT_W);
  localparam int MW = $clog2(MCLK_DIV+1);
  localparam int BW = $clog2(BCLK_DIV+1);
  localparam logic [MW-1:0] M_LAST = MW'(MCLK_DIV-1);
  localparam logic [BW-1:0] B_LAST = BW'(BCLK_DIV-1);
  localparam logic [NW-1:0] N_LAST = NW'(2*SLOT_W-1);
  localparam logic [NW-1:0] N_SLOT = NW'(SLOT_W);
  localparam logic [NW-1:0] N_SW   = NW'(SAMPLE_W);

  logic [MW-1:0] r_mcnt;
  logic          r_mclk;
  logic [BW-1:0] r_bcnt;
  logic          r_bclk;
  logic [NW-1:0] r_n;
  logic          r_run, r_lr, r_dac, r_tick, r_fmt, r_under, r_over;
  logic [FW-1:0] r_tx_sh, r_rx_sh;
  logic [FW-1:0] r_tx_mem [FIFO_DEPTH];
  logic [FW-1:0] r_rx_mem [FIFO_DEPTH];
  logic [AW:0]   r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;

  logic          w_btog, w_fall, w_rise, w_bound;
  logic [NW-1:0] w_n_nxt, w_d, w_tx_k, w_rx_k;
  logic          w_tx_win, w_rx_win;
  logic          w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
  logic          w_tx_pop, w_tx_push, w_rx_rd, w_rx_req, w_rx_push;
  logic [FW-1:0] w_tx_frame, w_tx_src;

  assign w_btog  = enable && r_bcnt == B_LAST;
  assign w_fall  = w_btog && r_bclk;
  assign w_rise  = w_btog && !r_bclk;
  // the first falling edge after enable always opens a fresh frame
  assign w_bound = w_fall && (!r_run || r_n == N_LAST);
  assign w_n_nxt = (!r_run || r_n == N_LAST) ? '0 : r_n + 1'b1;
  assign w_d     = {{(NW-1){1'b0}}, ~r_fmt};
  assign w_tx_k  = (w_n_nxt >= N_SLOT) ? w_n_nxt - N_SLOT : w_n_nxt;
  assign w_rx_k  = (r_n >= N_SLOT) ? r_n - N_SLOT : r_n;
  assign w_tx_win = (w_tx_k >= w_d) && (w_tx_k < N_SW + w_d);
  assign w_rx_win = (w_rx_k >= w_d) && (w_rx_k < N_SW + w_d);

  assign w_tx_empty = r_tx_wp == r_tx_rp;
  assign w_tx_full  = r_tx_wp == {~r_tx_rp[AW], r_tx_rp[AW-1:0]};
  assign w_rx_empty = r_rx_wp == r_rx_rp;
  assign w_rx_full  = r_rx_wp == {~r_rx_rp[AW], r_rx_rp[AW-1:0]};
  assign w_tx_pop   = w_bound && !w_tx_empty;
  assign w_tx_push  = tx_wr && (!w_tx_full || w_tx_pop);
  assign w_rx_rd    = rx_rd && !w_rx_empty;
  assign w_rx_req   = w_bound && r_run;
  assign w_rx_push  = w_rx_req && (!w_rx_full || w_rx_rd);
  assign w_tx_frame = w_tx_empty ? '0 : r_tx_mem[r_tx_rp[AW-1:0]];
  assign w_tx_src   = w_bound ? w_tx_frame : r_tx_sh;

  // free-running codec master clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mcnt <= '0;
      r_mclk <= 1'b0;
    end else if (r_mcnt == M_LAST) begin
      r_mcnt <= '0;
      r_mclk <= ~r_mclk;
    end else r_mcnt <= r_mcnt + 1'b1;
  end

  // bit clock runs only while enabled and parks low otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bcnt <= '0;
      r_bclk <= 1'b0;
    end else if (!enable) begin
      r_bcnt <= '0;
      r_bclk <= 1'b0;
    end else if (w_btog) begin
      r_bcnt <= '0;
      r_bclk <= ~r_bclk;
    end else r_bcnt <= r_bcnt + 1'b1;
  end

  // format is only allowed to change while the port is stopped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_fmt <= 1'b0;
    else if (!enable) r_fmt <= fmt;
  end

  // bit counter, frame clock, DAC shifter on falling edges and ADC shifter on rising edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_n, r_run, r_lr, r_dac, r_tick} <= '0;
      r_tx_sh <= '0;
      r_rx_sh <= '0;
    end else begin
      r_tick <= w_bound;
      if (!enable) begin
        {r_n, r_run, r_lr, r_dac} <= '0;
        r_tx_sh <= '0;
        r_rx_sh <= '0;
      end else begin
        if (w_fall) begin
          r_n     <= w_n_nxt;
          r_run   <= 1'b1;
          r_lr    <= (w_n_nxt >= N_SLOT) ^ r_fmt;
          r_dac   <= w_tx_win && w_tx_src[FW-1] && !mute;
          r_tx_sh <= w_tx_win ? w_tx_src << 1 : w_tx_src;
        end
        if (w_rise && r_run && w_rx_win) r_rx_sh <= {r_rx_sh[FW-2:0], adcdat};
      end
    end
  end

  // FIFO storage needs no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= tx_data;
    if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= r_rx_sh;
  end

  // FIFO pointers with one extra wrap bit to tell full from empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp} <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop) r_tx_rp <= r_tx_rp + 1'b1;
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_rd) r_rx_rp <= r_rx_rp + 1'b1;
    end
  end

  // sticky error flags; a new error beats a simultaneous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_under <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_under <= (r_under && !clr_err) || (w_bound && w_tx_empty);
      r_over  <= (r_over && !clr_err) || (w_rx_req && !w_rx_push);
    end
  end

  assign m_clk       = r_mclk;
  assign b_clk       = r_bclk;
  assign lr_clk      = r_lr;
  assign dacdat      = r_dac;
  assign frame_tick  = r_tick;
  assign tx_full     = w_tx_full;
  assign rx_empty    = w_rx_empty;
  assign rx_data     = w_rx_empty ? '0 : r_rx_mem[r_rx_rp[AW-1:0]];
  assign tx_underrun = r_under;
  assign rx_overrun  = r_over;
endmodule

// File: doc/audio_serdes.md
Name: audio_serdes

Overview:
Parametrised audio serial port for the WM8731 path. It generates MCLK, BCLK and a shared LRCLK, and serialises stereo frames to DACDAT from an internal TX FIFO. It deserialises ADCDAT into an internal RX FIFO. Sample width, slot width, clock dividers and FIFO depth are parameters, and I2S or left-justified format is selectable at run time. Sticky underrun/overrun flags are provided; it replaces the fixed-width serializer plus two external FIFOs in the codec controller.

Parameters:
SAMPLE_W, 16, bits per channel sample (8..32)
SLOT_W, 32, BCLK periods per channel slot; must be >= SAMPLE_W+1
BCLK_DIV, 4, clk cycles per BCLK half-period (>=1)
MCLK_DIV, 2, clk cycles per MCLK half-period (>=1)
FIFO_DEPTH, 4, frames per FIFO; power of 2, >=2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = run serial clocks and frames
fmt  in  1  0 = I2S, 1 = left-justified; latched while enable=0
mute  in  1  1 = DACDAT sends zeros; the TX FIFO still pops
m_clk  out  1  codec master clock
b_clk  out  1  bit clock
lr_clk  out  1  frame clock, shared by DAC and ADC
dacdat  out  1  serial DAC data
adcdat  in  1  serial ADC data
tx_data  in  2*SAMPLE_W  {left,right} frame to play
tx_wr  in  1  push tx_data
tx_full  out  1  TX FIFO full
rx_data  out  2*SAMPLE_W  {left,right} head of RX FIFO (show-ahead)
rx_rd  in  1  pop RX head
rx_empty  out  1  RX FIFO empty
tx_underrun  out  1  sticky: a frame started with the TX FIFO empty
rx_overrun  out  1  sticky: a captured frame was dropped because RX was full
clr_err  in  1  clears both sticky flags
frame_tick  out  1  one-clk pulse at each frame boundary

Behaviour:
- Reset: all outputs 0 except rx_empty=1. FIFOs, counters, shifters, flags and latched fmt are cleared. Reset is honoured at any time, including mid-frame.
- m_clk toggles every MCLK_DIV clk cycles regardless of enable.
- b_clk toggles every BCLK_DIV clk cycles while enable=1.
- enable=0: b_clk, lr_clk and dacdat are held 0 from the next clk. The bit counter and shifters are cleared, and any partial RX frame is discarded. FIFO contents and flags are kept. fmt is latched each cycle while enable=0.
- Bit counter n runs 0..2*SLOT_W-1 and advances on every b_clk falling edge. The slot is left when n<SLOT_W; k = n mod SLOT_W.
- lr_clk: I2S: 0 in the left slot, 1 in the right slot. Left-justified: 1 in the left slot, 0 in the right slot. lr_clk changes on b_clk falling edges.
- Delay D: 1 for I2S, 0 for left-justified.
- dacdat updates on b_clk falling edges. For D<=k<D+SAMPLE_W it drives sample bit SAMPLE_W-1-(k-D) of the current channel, MSB first. At all other k it drives 0.
- adcdat is sampled on b_clk rising edges at the same k positions. Bits outside that window are ignored.
- Frame boundary is the falling edge at which n wraps to 0; the first boundary is the first falling edge after enable rises. At each boundary:
  - frame_tick pulses for 1 clk.
  - TX: if the FIFO is non-empty, pop a frame into the shifter. If empty, load zeros and set tx_underrun.
  - mute=1: the shifter output is forced to 0.
  - RX: the frame completed in the previous frame period is pushed. If the RX FIFO is full, the frame is dropped and rx_overrun is set. No push occurs at the first boundary after enable.
- FIFOs: tx_wr when full is ignored; rx_rd when empty is ignored. A simultaneous read and write in the same cycle is allowed in both FIFOs, including when full or empty. rx_data is valid whenever rx_empty=0.
- Flags: clr_err clears both flags. If clr_err and a new error occur in the same cycle, the error wins and the flag stays 1.

Test Plan:
- Reset release with enable=0 -> b_clk, lr_clk and dacdat stay 0, rx_empty=1, and m_clk has period 2*MCLK_DIV clks.
- LJ loopback (adcdat=dacdat), defaults: push 0xA5A5_3C3C and 0x1234_8001, enable -> rx_data yields the same frames in order. lr_clk=1 on the first dacdat bit of left.
- I2S, same frames -> the first left MSB (1) appears one b_clk after lr_clk falls. Bits 17..31 of each slot are 0.
- enable with the TX FIFO empty -> dacdat all 0 and tx_underrun=1. Then pulse clr_err -> tx_underrun=0.
- Loopback with no rx_rd for 5 frames (depth 4) -> rx_overrun=1 and the first four frames are retained unchanged.
- mute=1 with 2 frames queued -> dacdat 0 and tx_full/FIFO count drop by 2 after 2 frame_ticks. enable dropped mid-frame -> b_clk=0 next clk, with no partial RX push.
